// File: rtl/echo_bus_sequencer.sv
// Shares the echo peripheral between two requesters (round robin), sequences LATCH/FIRE,
// captures the shifted echo and flags any mismatch against the locally computed result.
module echo_bus_sequencer #(
    parameter int SETTLE = 2,
    parameter int DW     = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [1:0]    req_valid,
    input  logic [DW-1:0] req_data0,
    input  logic [DW-1:0] req_data1,
    output logic [1:0]    req_ready,
    output logic          rsp_valid,
    output logic          rsp_id,
    output logic [DW-1:0] rsp_data,
    output logic          rsp_err,
    output logic [7:0]    cmd,
    output logic [DW-1:0] pdata_out,
    input  logic [DW-1:0] pdata_in
);
    // state   | meaning
    // IDLE    | arbitrate, cmd=00
    // SETUP   | present operand, cmd=00
    // LATCH   | SETTLE cycles, cmd=02 (peripheral latches)
    // FIRE    | SETTLE cycles, cmd=01 (peripheral drives)
    // CAPTURE | sample pdata_in, cmd=01
    typedef enum logic [2:0] {IDLE, SETUP, LATCH, FIRE, CAPTURE} state_t;

    localparam int CW = 4;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          last_grant_q, last_grant_d;
    logic          id_q, id_d;
    logic [DW-1:0] expected_q, expected_d;
    logic [DW-1:0] pdata_out_q, pdata_out_d;
    logic [7:0]    cmd_q, cmd_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic          rsp_id_q, rsp_id_d;
    logic [DW-1:0] rsp_data_q, rsp_data_d;
    logic          rsp_err_q, rsp_err_d;
    logic [1:0]    grant;
    logic          accept;
    logic [DW-1:0] operand;

    always_comb begin
        grant = 2'b00;
        case (req_valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_grant_q ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    assign req_ready = (state_q == IDLE && !reset) ? grant : 2'b00;
    assign accept    = |(req_ready & req_valid);
    assign operand   = req_ready[1] ? req_data1 : req_data0;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        id_d         = id_q;
        expected_d   = expected_q;
        pdata_out_d  = pdata_out_q;
        rsp_valid_d  = 1'b0;
        rsp_id_d     = rsp_id_q;
        rsp_data_d   = rsp_data_q;
        rsp_err_d    = rsp_err_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d      = SETUP;
                    id_d         = req_ready[1];
                    last_grant_d = req_ready[1];
                    pdata_out_d  = operand;
                    expected_d   = {operand[DW-4:0], 3'b000};
                end
            end
            SETUP: begin
                state_d = LATCH;
                cnt_d   = CW'(SETTLE - 1);
            end
            LATCH: begin
                if (cnt_q == '0) begin
                    state_d = FIRE;
                    cnt_d   = CW'(SETTLE - 1);
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            FIRE: begin
                if (cnt_q == '0) state_d = CAPTURE;
                else             cnt_d   = cnt_q - CW'(1);
            end
            CAPTURE: begin
                state_d     = IDLE;
                rsp_valid_d = 1'b1;
                rsp_id_d    = id_q;
                rsp_data_d  = pdata_in;
                rsp_err_d   = (pdata_in != expected_q);
            end
            default: state_d = IDLE;
        endcase

        // cmd follows the state being entered so it only changes on state entry
        case (state_d)
            LATCH:         cmd_d = 8'h02;
            FIRE, CAPTURE: cmd_d = 8'h01;
            default:       cmd_d = 8'h00;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            last_grant_q <= 1'b1;
            id_q         <= 1'b0;
            expected_q   <= '0;
            pdata_out_q  <= '0;
            cmd_q        <= 8'h00;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_data_q   <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            id_q         <= id_d;
            expected_q   <= expected_d;
            pdata_out_q  <= pdata_out_d;
            cmd_q        <= cmd_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_data_q   <= rsp_data_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    assign cmd       = cmd_q;
    assign pdata_out = pdata_out_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_echo_bus_sequencer.sv
// Self-checking bench for echo_bus_sequencer: default build plus a SETTLE=1 build,
// each with a behavioural echo peripheral attached.
module tb_echo_bus_sequencer;
    logic        clk = 1'b0;
    logic        reset;
    int          errors = 0;
    int          checks = 0;

    // default build
    logic [1:0]  req_valid;
    logic [15:0] req_data0, req_data1;
    logic [1:0]  req_ready;
    logic        rsp_valid, rsp_id, rsp_err;
    logic [15:0] rsp_data, pdata_out;
    logic [7:0]  cmd;
    wire  [15:0] pdata_in;

    // SETTLE=1 build
    logic [1:0]  req_valid1;
    logic [15:0] req_data0_1, req_data1_1;
    logic [1:0]  req_ready1;
    logic        rsp_valid1, rsp_id1, rsp_err1;
    logic [15:0] rsp_data1, pdata_out1;
    logic [7:0]  cmd1;
    wire  [15:0] pdata_in1;

    always #5 clk = ~clk;

    echo_bus_sequencer #(.SETTLE(2), .DW(16)) u_dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_data0(req_data0),
        .req_data1(req_data1), .req_ready(req_ready), .rsp_valid(rsp_valid),
        .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err), .cmd(cmd),
        .pdata_out(pdata_out), .pdata_in(pdata_in));

    echo_bus_sequencer #(.SETTLE(1), .DW(16)) u_dut1 (
        .clk(clk), .reset(reset), .req_valid(req_valid1), .req_data0(req_data0_1),
        .req_data1(req_data1_1), .req_ready(req_ready1), .rsp_valid(rsp_valid1),
        .rsp_id(rsp_id1), .rsp_data(rsp_data1), .rsp_err(rsp_err1), .cmd(cmd1),
        .pdata_out(pdata_out1), .pdata_in(pdata_in1));

    // Echo peripheral models: latch on a command change with bit0 low, drive word<<3 when bit0 high
    logic [15:0] latched0 = 16'h0, latched1 = 16'h0;
    logic        frc_en = 1'b0;
    logic [15:0] frc_val = 16'h0;
    always @(cmd)  if (cmd[0] == 1'b0)  latched0 = pdata_out;
    always @(cmd1) if (cmd1[0] == 1'b0) latched1 = pdata_out1;
    assign pdata_in  = cmd[0]  ? (frc_en ? frc_val : {latched0[12:0], 3'b000}) : 16'hzzzz;
    assign pdata_in1 = cmd1[0] ? {latched1[12:0], 3'b000} : 16'hzzzz;

    // Reference arbitration memory: which requester won the last accept
    logic        mdl_last = 1'b1;

    logic [7:0]  cmd_log [0:20];
    int          rsp_cnt;
    logic        r_id, r_err;
    logic [15:0] r_data;

    function automatic logic [7:0] exp_cmd(input int k, input int s);
        if (k == 1)              return 8'h00;
        else if (k <= 1 + s)     return 8'h02;
        else if (k <= 2 + 2 * s) return 8'h01;
        else                     return 8'h00;
    endfunction

    // Offers one request, then watches 20 cycles after the accept edge.
    task automatic run_txn(input logic [1:0] v, input logic [15:0] d0, input logic [15:0] d1,
                           output logic [1:0] rdy, output int lat);
        @(negedge clk);
        req_valid = v; req_data0 = d0; req_data1 = d1;
        #1 rdy = req_ready;
        @(posedge clk);
        lat = -1; rsp_cnt = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) req_valid = 2'b00;
            cmd_log[k] = cmd;
            if (rsp_valid) begin
                rsp_cnt++;
                if (lat < 0) begin lat = k; r_id = rsp_id; r_data = rsp_data; r_err = rsp_err; end
            end
        end
    endtask

    task automatic test_reset();
        req_valid = 2'b11; req_valid1 = 2'b11;
        #1;
        checks++; if (cmd !== 8'h00) begin errors++; $display("FAIL reset_cmd got=%h want=00", cmd); end
        checks++; if (pdata_out !== 16'h0) begin errors++; $display("FAIL reset_pdata_out got=%h want=0000", pdata_out); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got=%b want=0", rsp_valid); end
        checks++; if ({rsp_id, rsp_err, rsp_data} !== 18'h0) begin errors++; $display("FAIL reset_rsp got=%b/%b/%h want=0/0/0000", rsp_id, rsp_err, rsp_data); end
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_ready got=%b want=00", req_ready); end
        checks++; if (req_ready1 !== 2'b00 || cmd1 !== 8'h00) begin errors++; $display("FAIL reset_s1 got=%b/%h want=00/00", req_ready1, cmd1); end
        req_valid = 2'b00; req_valid1 = 2'b00;
        @(negedge clk) reset = 1'b0;
        mdl_last = 1'b1;
    endtask

    task automatic test_single();
        logic [1:0] rdy; int lat;
        run_txn(2'b01, 16'h0001, 16'h0000, rdy, lat);
        checks++; if (rdy !== 2'b01) begin errors++; $display("FAIL single_ready got=%b want=01", rdy); end
        for (int k = 1; k <= 6; k++) begin
            checks++;
            if (cmd_log[k] !== exp_cmd(k, 2)) begin errors++; $display("FAIL single_cmd cycle=%0d got=%h want=%h", k, cmd_log[k], exp_cmd(k, 2)); end
        end
        checks++; if (lat != 7) begin errors++; $display("FAIL single_latency got=%0d want=7", lat); end
        checks++; if (r_data !== 16'h0008 || r_id !== 1'b0 || r_err !== 1'b0) begin errors++; $display("FAIL single_rsp got=%h/%b/%b want=0008/0/0", r_data, r_id, r_err); end
        checks++; if (rsp_cnt != 1) begin errors++; $display("FAIL single_pulses got=%0d want=1", rsp_cnt); end
        mdl_last = 1'b0;
    endtask

    task automatic test_truncation();
        logic [1:0] rdy; int lat;
        run_txn(2'b10, 16'h0000, 16'hFFFF, rdy, lat);
        checks++; if (rdy !== 2'b10) begin errors++; $display("FAIL trunc_ready got=%b want=10", rdy); end
        checks++; if (lat != 7) begin errors++; $display("FAIL trunc_latency got=%0d want=7", lat); end
        checks++; if (r_data !== 16'hFFF8 || r_id !== 1'b1 || r_err !== 1'b0) begin errors++; $display("FAIL trunc_rsp got=%h/%b/%b want=fff8/1/0", r_data, r_id, r_err); end
        mdl_last = 1'b1;
    endtask

    task automatic test_back_to_back();
        int cyc [0:3]; logic ids [0:3]; logic [15:0] dat [0:3];
        int n = 0; logic want_id;
        @(negedge clk);
        req_valid = 2'b11; req_data0 = 16'h0010; req_data1 = 16'h0020;
        for (int c = 0; c < 60 && n < 4; c++) begin
            @(negedge clk);
            if (rsp_valid) begin
                cyc[n] = c; ids[n] = rsp_id; dat[n] = rsp_data; n++;
                if (n == 4) req_valid = 2'b00;
            end
        end
        req_valid = 2'b00;
        checks++; if (n != 4) begin errors++; $display("FAIL b2b_count got=%0d want=4", n); end
        want_id = mdl_last ? 1'b0 : 1'b1;
        for (int i = 0; i < n; i++) begin
            checks++;
            if (ids[i] !== want_id || dat[i] !== (want_id ? 16'h0100 : 16'h0080)) begin
                errors++; $display("FAIL b2b_rsp idx=%0d got=%b/%h want=%b/%h", i, ids[i], dat[i], want_id, want_id ? 16'h0100 : 16'h0080);
            end
            if (i > 0) begin
                checks++;
                if (cyc[i] - cyc[i-1] != 7) begin errors++; $display("FAIL b2b_spacing idx=%0d got=%0d want=7", i, cyc[i] - cyc[i-1]); end
            end
            mdl_last = want_id;
            want_id = ~want_id;
        end
        repeat (10) @(negedge clk);
    endtask

    task automatic test_error_inject();
        logic [1:0] rdy; int lat;
        frc_en = 1'b1; frc_val = 16'h1234;
        run_txn(2'b01, 16'h0002, 16'h0000, rdy, lat);
        frc_en = 1'b0;
        checks++; if (rdy !== 2'b01) begin errors++; $display("FAIL err_ready got=%b want=01", rdy); end
        checks++; if (r_data !== 16'h1234 || r_err !== 1'b1 || r_id !== 1'b0) begin errors++; $display("FAIL err_rsp got=%h/%b/%b want=1234/1/0", r_data, r_err, r_id); end
        mdl_last = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [1:0] rdy; int lat; int pulses = 0;
        @(negedge clk);
        req_valid = 2'b01; req_data0 = 16'h0005;
        @(posedge clk);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (k == 1) req_valid = 2'b00;
        end
        checks++; if (cmd !== 8'h01) begin errors++; $display("FAIL mid_in_fire got=%h want=01", cmd); end
        #2 reset = 1'b1;
        #1;
        checks++; if (cmd !== 8'h00 || pdata_out !== 16'h0) begin errors++; $display("FAIL mid_cmd got=%h/%h want=00/0000", cmd, pdata_out); end
        checks++; if (rsp_data !== 16'h0 || rsp_err !== 1'b0 || rsp_valid !== 1'b0) begin errors++; $display("FAIL mid_rsp got=%h/%b/%b want=0000/0/0", rsp_data, rsp_err, rsp_valid); end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        mdl_last = 1'b1;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (rsp_valid) pulses++;
        end
        checks++; if (pulses != 0) begin errors++; $display("FAIL mid_no_rsp got=%0d want=0", pulses); end
        run_txn(2'b11, 16'h0003, 16'h0007, rdy, lat);
        checks++; if (rdy !== 2'b01) begin errors++; $display("FAIL mid_tie_ready got=%b want=01", rdy); end
        checks++; if (r_data !== 16'h0018 || r_id !== 1'b0 || lat != 7) begin errors++; $display("FAIL mid_after_rsp got=%h/%b/%0d want=0018/0/7", r_data, r_id, lat); end
        mdl_last = 1'b0;
    endtask

    task automatic test_settle1();
        int lat = -1; logic [1:0] rdy; logic [7:0] clog [1:12];
        logic [15:0] d; logic e;
        @(negedge clk);
        req_valid1 = 2'b01; req_data0_1 = 16'h8001; req_data1_1 = 16'h0000;
        #1 rdy = req_ready1;
        @(posedge clk);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == 1) req_valid1 = 2'b00;
            clog[k] = cmd1;
            if (rsp_valid1 && lat < 0) begin lat = k; d = rsp_data1; e = rsp_err1; end
        end
        checks++; if (rdy !== 2'b01) begin errors++; $display("FAIL s1_ready got=%b want=01", rdy); end
        for (int k = 1; k <= 4; k++) begin
            checks++;
            if (clog[k] !== exp_cmd(k, 1)) begin errors++; $display("FAIL s1_cmd cycle=%0d got=%h want=%h", k, clog[k], exp_cmd(k, 1)); end
        end
        checks++; if (lat != 5) begin errors++; $display("FAIL s1_latency got=%0d want=5", lat); end
        checks++; if (d !== 16'h0008 || e !== 1'b0) begin errors++; $display("FAIL s1_rsp got=%h/%b want=0008/0", d, e); end
    endtask

    task automatic test_random();
        logic [1:0] rdy, v, want_rdy; int lat;
        logic [15:0] op0, op1, op, want_data, ideal;
        logic want_id, frc;
        for (int it = 0; it < 40; it++) begin
            v   = 2'($urandom_range(1, 3));
            op0 = 16'($urandom); op1 = 16'($urandom);
            frc = ($urandom_range(0, 3) == 0);
            frc_en = frc; frc_val = 16'($urandom);
            if (v == 2'b11) want_id = ~mdl_last;
            else            want_id = v[1];
            want_rdy  = want_id ? 2'b10 : 2'b01;
            op        = want_id ? op1 : op0;
            ideal     = 16'((op * 8) % 65536);
            want_data = frc ? frc_val : ideal;
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run_txn(v, op0, op1, rdy, lat);
            frc_en = 1'b0;
            checks++; if (rdy !== want_rdy) begin errors++; $display("FAIL rnd_ready it=%0d got=%b want=%b", it, rdy, want_rdy); end
            checks++;
            if (lat != 7 || rsp_cnt != 1 || r_id !== want_id || r_data !== want_data || r_err !== (want_data != ideal)) begin
                errors++;
                $display("FAIL rnd_rsp it=%0d got lat=%0d n=%0d id=%b data=%h err=%b want lat=7 n=1 id=%b data=%h err=%b",
                         it, lat, rsp_cnt, r_id, r_data, r_err, want_id, want_data, want_data != ideal);
            end
            mdl_last = want_id;
        end
    endtask

    initial begin
        reset = 1'b1;
        req_valid = 2'b00; req_data0 = 16'h0; req_data1 = 16'h0;
        req_valid1 = 2'b00; req_data0_1 = 16'h0; req_data1_1 = 16'h0;
        #12;
        test_reset();
        test_single();
        test_truncation();
        test_back_to_back();
        test_error_inject();
        test_reset_mid();
        test_settle1();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
